// File: rtl/color_sequencer.sv
// Button front end and run/stop, manual/auto sequencer feeding the RGB colour decoder.
// Optional AUTO mode (step timer and btn_mode path) is compiled in by COLOR_SEQ_AUTO_EN.
module color_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP_CYCLES     = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_next,
  input  logic       btn_mode,
  output logic [1:0] color_value,
  output logic       main_program,
  output logic       auto_active
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef COLOR_SEQ_AUTO_EN
  localparam int NUM_BTN = 3;
  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, AUTO} state_t;
`else
  localparam int NUM_BTN = 2;

  typedef enum logic {IDLE, MANUAL} state_t;
`endif

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

`ifdef COLOR_SEQ_AUTO_EN
  assign btn_raw = {btn_mode, btn_next, btn_run};
`else
  logic unused_mode;
  assign btn_raw     = {btn_next, btn_run};
  assign unused_mode = btn_mode;
`endif

  // Per button: 2-flop synchroniser, run-length debouncer, registered rising-edge pulse.
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic            sync1_reg;
    logic            sync2_reg;
    logic            deb_reg;
    logic            deb_prev_reg;
    logic            press_reg;
    logic [DB_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_reg    <= 1'b0;
        sync2_reg    <= 1'b0;
        deb_reg      <= 1'b0;
        deb_prev_reg <= 1'b0;
        press_reg    <= 1'b0;
        cnt_reg      <= '0;
      end else begin
        sync1_reg <= btn_raw[gi];
        sync2_reg <= sync1_reg;
        if (sync2_reg == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_LAST) begin
          deb_reg <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        deb_prev_reg <= deb_reg;
        press_reg    <= deb_reg & ~deb_prev_reg;
      end
    end

    assign press[gi] = press_reg;
  end

  logic run_press;
  logic next_press;
  assign run_press  = press[0];
  assign next_press = press[1];

`ifdef COLOR_SEQ_AUTO_EN
  logic              mode_press;
  logic [STEP_W-1:0] step_reg;
  logic [STEP_W-1:0] step_next;
  assign mode_press = press[2];
`endif

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] color_reg;
  logic [1:0] color_next;
  logic       main_program_reg;
  logic       auto_active_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      color_reg        <= 2'd0;
      main_program_reg <= 1'b0;
      auto_active_reg  <= 1'b0;
`ifdef COLOR_SEQ_AUTO_EN
      step_reg         <= '0;
`endif
    end else begin
      state_reg        <= state_next;
      color_reg        <= color_next;
      main_program_reg <= (state_next != IDLE);
`ifdef COLOR_SEQ_AUTO_EN
      auto_active_reg  <= (state_next == AUTO);
      step_reg         <= step_next;
`else
      auto_active_reg  <= 1'b0;
`endif
    end
  end

  // Priority within a cycle: run, then mode, then next / step timer.
  always_comb begin
    state_next = state_reg;
    color_next = color_reg;
`ifdef COLOR_SEQ_AUTO_EN
    step_next  = step_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (run_press) state_next = MANUAL;
      end
      MANUAL: begin
        if (run_press) begin
          state_next = IDLE;
`ifdef COLOR_SEQ_AUTO_EN
        end else if (mode_press) begin
          state_next = AUTO;
          step_next  = '0;
`endif
        end else if (next_press) begin
          color_next = color_reg + 2'd1;
        end
      end
`ifdef COLOR_SEQ_AUTO_EN
      AUTO: begin
        if (run_press) begin
          state_next = IDLE;
        end else if (mode_press) begin
          state_next = MANUAL;
        end else if (next_press || step_reg == STEP_LAST) begin
          // A coincident next press and terminal count collapse into one step.
          color_next = color_reg + 2'd1;
          step_next  = '0;
        end else begin
          step_next = step_reg + 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign color_value  = color_reg;
  assign main_program = main_program_reg;
  assign auto_active  = auto_active_reg;

endmodule

// File: tb/tb_color_sequencer.sv
// Randomised and directed bench for color_sequencer against an edge-indexed behavioural model.
// Honours COLOR_SEQ_AUTO_EN the same way as the design.
module tb_color_sequencer;
  localparam int DB = 4;
  localparam int ST = 8;
  localparam int HL = DB + 2;
`ifdef COLOR_SEQ_AUTO_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_mode = 1'b0;
  logic [1:0] color_value;
  logic       main_program;
  logic       auto_active;

  color_sequencer #(.DEBOUNCE_CYCLES(DB), .STEP_CYCLES(ST)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_next(btn_next), .btn_mode(btn_mode),
    .color_value(color_value), .main_program(main_program), .auto_active(auto_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_no  = 0;

  // Model: raw level history per button (index 0 = level present at the latest edge).
  int hist [3][HL];
  int deb  [3];
  int due  [3];
  int m_state;     // 0 idle, 1 manual, 2 auto
  int m_color;
  int m_anchor;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_no, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < HL; k++) hist[i][k] = 0;
      deb[i] = 0;
      due[i] = -1;
    end
    m_state = 0; m_color = 0; m_anchor = 0;
  endtask

  task automatic model_edge(input logic [2:0] b);
    bit run, nxt, mode, all_diff;
    run  = (due[0] == edge_no);
    nxt  = (due[1] == edge_no);
    mode = (due[2] == edge_no) && AUTO_EN;
    case (m_state)
      0: if (run) m_state = 1;
      1: begin
        if (run) m_state = 0;
        else if (mode) begin m_state = 2; m_anchor = edge_no; end
        else if (nxt) m_color = (m_color + 1) % 4;
      end
      default: begin
        if (run) m_state = 0;
        else if (mode) m_state = 1;
        else if (nxt || edge_no - m_anchor == ST) begin
          m_color = (m_color + 1) % 4;
          m_anchor = edge_no;
        end
      end
    endcase
    // A level is accepted once the synchronised input has disagreed for DB consecutive edges.
    for (int i = 0; i < 3; i++) begin
      for (int k = HL - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = int'(b[i]);
      all_diff = 1'b1;
      for (int k = 2; k < HL; k++) if (hist[i][k] == deb[i]) all_diff = 1'b0;
      if (all_diff) begin
        deb[i] = 1 - deb[i];
        if (deb[i] == 1) due[i] = edge_no + 2;
      end
    end
  endtask

  task automatic tick(input logic [2:0] b);
    btn_run = b[0]; btn_next = b[1]; btn_mode = b[2];
    @(posedge clk);
    edge_no++;
    model_edge(b);
    #1;
    check("color", int'(color_value), m_color);
    check("main_program", int'(main_program), int'(m_state != 0));
    check("auto_active", int'(auto_active), int'(m_state == 2));
  endtask

  task automatic press(input logic [2:0] b, input int hold, input int gap);
    for (int k = 0; k < hold; k++) tick(b);
    for (int k = 0; k < gap; k++) tick(3'b000);
  endtask

  task automatic do_reset();
    btn_run = 1'b0; btn_next = 1'b0; btn_mode = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_color", int'(color_value), 0);
    check("rst_main", int'(main_program), 0);
    check("rst_auto", int'(auto_active), 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  int exp_seq [4] = '{1, 2, 3, 0};
  int lat, t_rise, c_prev, last_chg, interval, first_chg, second_chg, c_hold;
  bit seen;

  initial begin
    model_reset();
    do_reset();

    // next/mode in IDLE are ignored
    press(3'b010, 10, 8);
    press(3'b100, 10, 8);
    check("idle_color", int'(color_value), 0);
    check("idle_main", int'(main_program), 0);

    // 3-cycle glitch on run
    press(3'b001, 3, 8);
    check("glitch_main", int'(main_program), 0);

    // held run: latency and single event
    t_rise = edge_no + 1; seen = 0; lat = -1;
    for (int k = 0; k < 20; k++) begin
      tick(3'b001);
      if (!seen && main_program) begin seen = 1; lat = edge_no - t_rise; end
    end
    check("run_latency", lat, 7);
    press(3'b000, 0, 8);
    check("run_held_once", int'(main_program), 1);

    // manual wrap
    for (int i = 0; i < 4; i++) begin
      press(3'b010, 6, 6);
      check("wrap", int'(color_value), exp_seq[i]);
    end

    // mode press
    c_hold = int'(color_value);
    press(3'b100, 6, 2);
    check("mode_auto", int'(auto_active), int'(AUTO_EN));
    if (AUTO_EN) begin
      c_prev = int'(color_value); last_chg = -1; interval = -1;
      for (int k = 0; k < 40; k++) begin
        tick(3'b000);
        if (int'(color_value) != c_prev) begin
          if (last_chg >= 0 && interval < 0) interval = edge_no - last_chg;
          last_chg = edge_no; c_prev = int'(color_value);
        end
      end
      check("auto_interval", interval, ST);
      // align on a step, then a next press lands mid-interval
      c_prev = int'(color_value);
      for (int k = 0; k < 2 * ST && int'(color_value) == c_prev; k++) tick(3'b000);
      t_rise = edge_no + 1; c_prev = int'(color_value); first_chg = -1; second_chg = -1;
      for (int k = 0; k < 24; k++) begin
        tick(k < 6 ? 3'b010 : 3'b000);
        if (int'(color_value) != c_prev) begin
          if (first_chg < 0) first_chg = edge_no; else if (second_chg < 0) second_chg = edge_no;
          c_prev = int'(color_value);
        end
      end
      check("next_in_auto", first_chg - t_rise, DB + 3);
      check("restart_interval", second_chg - first_chg, ST);
      press(3'b100, 6, 4);
    end else begin
      press(3'b000, 0, 20);
      check("no_step", int'(color_value), c_hold);
    end

    // run and mode together in MANUAL
    check("pre_prio_manual", int'(main_program), 1);
    press(3'b101, 6, 6);
    check("prio_main", int'(main_program), 0);
    check("prio_auto", int'(auto_active), 0);

    // random stimulus
    for (int it = 0; it < 80; it++) begin
      if (it == 40) do_reset();
      press(3'($urandom_range(0, 7)), $urandom_range(1, 10), $urandom_range(0, 8));
    end

    // reset mid-AUTO (mid-MANUAL without the feature)
    do_reset();
    press(3'b001, 6, 4);
    press(3'b100, 6, 3);
    check("pre_rst_main", int'(main_program), 1);
    do_reset();
    press(3'b000, 0, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
